// File: rtl/multi_interval_timer.sv
// multi_interval_timer
//   NUM_CH independent interval timers. Each channel counts clock cycles up to
//   its latched terminal count and emits a one-cycle done pulse at expiry. The
//   channel then either stops (one-shot) or reloads and keeps counting (periodic).
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   start     : [NUM_CH] pulse, start/restart channel (count=0, latch term and mode)
//   stop      : [NUM_CH] pulse, abort channel to IDLE
//   pause     : [NUM_CH] level, hold the count while high (ignored in IDLE)
//   periodic  : [NUM_CH] mode bit sampled on start (1 = auto-reload)
//   load_en   : write load_val into the terminal register of channel load_ch
//   load_ch   : channel index for the load
//   load_val  : new terminal count (0 is stored as 1)
//   busy      : [NUM_CH] channel in RUN or PAUSED
//   done      : [NUM_CH] registered one-cycle expiry pulse
//   count     : [NUM_CH*WIDTH] current counts, channel i at [i*WIDTH +: WIDTH]
module multi_interval_timer #(
   parameter int unsigned WIDTH        = 27,
   parameter int unsigned NUM_CH       = 4,
   parameter int unsigned DEFAULT_TERM = 100_000_000,
   localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_CH-1:0]         start,
   input  logic [NUM_CH-1:0]         stop,
   input  logic [NUM_CH-1:0]         pause,
   input  logic [NUM_CH-1:0]         periodic,
   input  logic                      load_en,
   input  logic [CH_W-1:0]           load_ch,
   input  logic [WIDTH-1:0]          load_val,
   output logic [NUM_CH-1:0]         busy,
   output logic [NUM_CH-1:0]         done,
   output logic [NUM_CH*WIDTH-1:0]   count
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] TERM_RST = WIDTH'(DEFAULT_TERM);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   // per-channel FSM state
   state_t           state_q [NUM_CH];
   state_t           state_d [NUM_CH];

   // per-channel datapath registers
   logic [WIDTH-1:0] term_q  [NUM_CH];
   logic [WIDTH-1:0] term_d  [NUM_CH];
   logic [WIDTH-1:0] aterm_q [NUM_CH];
   logic [WIDTH-1:0] aterm_d [NUM_CH];
   logic [WIDTH-1:0] cnt_q   [NUM_CH];
   logic [WIDTH-1:0] cnt_d   [NUM_CH];
   logic [NUM_CH-1:0] mode_q;
   logic [NUM_CH-1:0] mode_d;
   logic [NUM_CH-1:0] busy_q;
   logic [NUM_CH-1:0] busy_d;
   logic [NUM_CH-1:0] done_q;
   logic [NUM_CH-1:0] done_d;

   // decoded events
   logic [NUM_CH-1:0] load_hit_c;
   logic [NUM_CH-1:0] tick_c;
   logic [NUM_CH-1:0] expire_c;
   logic [WIDTH-1:0]  load_adj_c;

   // Event decode: load target, counting edge, and expiry edge per channel.
   // A channel leaving PAUSED counts on that edge, so it is treated like RUN.
   always_comb begin
      load_adj_c = (load_val == '0) ? ONE : load_val;
      for (int i = 0; i < NUM_CH; i++) begin
         load_hit_c[i] = load_en && (load_ch == CH_W'(i));
         tick_c[i]     = (state_q[i] != ST_IDLE) && !pause[i];
         expire_c[i]   = tick_c[i] && (cnt_q[i] == (aterm_q[i] - ONE));
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (!rst_n) begin
            state_q[i] <= ST_IDLE;
         end else begin
            state_q[i] <= state_d[i];
         end
      end
   end

   // FSM next state: stop > start > expiry > pause
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         state_d[i] = state_q[i];
         if (stop[i]) begin
            state_d[i] = ST_IDLE;
         end else if (start[i]) begin
            state_d[i] = ST_RUN;
         end else begin
            case (state_q[i])
               ST_RUN, ST_PAUSED: begin
                  if (expire_c[i]) begin
                     state_d[i] = mode_q[i] ? ST_RUN : ST_IDLE;
                  end else if (pause[i]) begin
                     state_d[i] = ST_PAUSED;
                  end else begin
                     state_d[i] = ST_RUN;
                  end
               end
               default: state_d[i] = ST_IDLE;
            endcase
         end
      end
   end

   // FSM outputs and datapath next values
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i]   = cnt_q[i];
         done_d[i]  = 1'b0;
         aterm_d[i] = aterm_q[i];
         mode_d[i]  = mode_q[i];
         term_d[i]  = term_q[i];
         busy_d[i]  = (state_d[i] != ST_IDLE);

         if (load_hit_c[i]) begin
            term_d[i] = load_adj_c;
         end

         if (stop[i]) begin
            cnt_d[i] = '0;
         end else if (start[i]) begin
            // a load to this channel in the same cycle is seen by the start
            cnt_d[i]   = '0;
            aterm_d[i] = load_hit_c[i] ? load_adj_c : term_q[i];
            mode_d[i]  = periodic[i];
         end else if (expire_c[i]) begin
            cnt_d[i]  = '0;
            done_d[i] = 1'b1;
         end else if (tick_c[i]) begin
            cnt_d[i] = cnt_q[i] + ONE;
         end
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (!rst_n) begin
            cnt_q[i]   <= '0;
            term_q[i]  <= TERM_RST;
            aterm_q[i] <= TERM_RST;
            mode_q[i]  <= 1'b0;
            busy_q[i]  <= 1'b0;
            done_q[i]  <= 1'b0;
         end else begin
            cnt_q[i]   <= cnt_d[i];
            term_q[i]  <= term_d[i];
            aterm_q[i] <= aterm_d[i];
            mode_q[i]  <= mode_d[i];
            busy_q[i]  <= busy_d[i];
            done_q[i]  <= done_d[i];
         end
      end
   end

   assign busy = busy_q;
   assign done = done_q;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_count
      assign count[g*WIDTH +: WIDTH] = cnt_q[g];
   end

endmodule

// File: doc/multi_interval_timer.md
MULTI_INTERVAL_TIMER -- requirements
Module: multi_interval_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 27, giving the per-channel counter and terminal width in bits.
REQ-002 The block SHALL have parameter NUM_CH, default 4, giving the number of independent timer channels (range 1..16).
REQ-003 The block SHALL have parameter DEFAULT_TERM, default 100_000_000, giving the reset terminal count of every channel (1 s at 100 MHz).
REQ-004 Port clk, input, 1, the clock; all logic SHALL be rising-edge triggered.
REQ-005 Port rst_n, input, 1, the reset; synchronous and active-low.
REQ-006 Port start, input, NUM_CH, one bit per channel; a 1-cycle pulse starts or restarts that channel.
REQ-007 Port stop, input, NUM_CH, one bit per channel; a 1-cycle pulse aborts that channel.
REQ-008 Port pause, input, NUM_CH, one bit per channel; a level that holds the count while high.
REQ-009 Port periodic, input, NUM_CH, one bit per channel; the mode bit (1 = auto-reload, 0 = one-shot), sampled only on start.
REQ-010 Port load_en, input, 1, writes load_val into the terminal register of the channel selected by load_ch.
REQ-011 Port load_ch, input, clog2(NUM_CH) (minimum 1), the channel index for the load.
REQ-012 Port load_val, input, WIDTH, the new terminal count.
REQ-013 Port busy, output, NUM_CH, one bit per channel; high when the channel is in RUN or PAUSED.
REQ-014 Port done, output, NUM_CH, one bit per channel; a registered 1-cycle pulse at each expiry.
REQ-015 Port count, output, NUM_CH*WIDTH, the per-channel current counts; channel i occupies bits [i*WIDTH +: WIDTH].

Function
REQ-016 Each channel SHALL have its own FSM with states IDLE, RUN and PAUSED, and its own term_reg, active_term and mode registers.
REQ-017 Load: when load_en=1 and load_ch<NUM_CH, term_reg[load_ch] SHALL take load_val at the next edge; load_val=0 SHALL be stored as 1; load_ch>=NUM_CH SHALL be ignored.
REQ-018 A load SHALL NOT affect a running channel; active_term and mode SHALL be latched only on start.
REQ-019 When load and start hit the same channel in the same cycle, the start SHALL latch the new (0-adjusted) load_val.
REQ-020 Start from any state: at the next edge the channel SHALL go to RUN with count=0, active_term=term_reg and mode=periodic, and no done pulse.
REQ-021 RUN with pause=0: count SHALL increment by 1 per cycle.
REQ-022 RUN at expiry (pause=0, count==active_term-1): at the next edge done SHALL be 1 for exactly one cycle and count SHALL become 0.
REQ-023 After expiry, mode=0 (one-shot) SHALL take the channel to IDLE, and mode=1 (periodic) SHALL keep it in RUN.
REQ-024 The expiry period SHALL therefore be active_term cycles, and active_term=1 in periodic mode SHALL give done every cycle.
REQ-025 RUN with pause=1 SHALL take the channel to PAUSED with count held; PAUSED with pause=0 SHALL return it to RUN, with counting resuming on that edge.
REQ-026 No expiry SHALL occur while the channel is in PAUSED, and the pause input SHALL be ignored in IDLE.
REQ-027 Stop SHALL take the channel to IDLE with count=0 and no done at the next edge, from any state.
REQ-028 Priority per channel SHALL be stop > start > expiry > pause.
REQ-029 start and expiry in the same cycle SHALL restart the channel with no done pulse.
REQ-030 In IDLE, count SHALL be 0 and done SHALL be 0.
REQ-031 count SHALL never exceed active_term-1 and SHALL never wrap through 2^WIDTH.
REQ-032 Channels SHALL be fully independent; events on one channel SHALL never alter another channel's state.
REQ-033 All outputs SHALL be driven directly from registers, with no combinational path from input to output.

Reset
REQ-034 While rst_n=0 at a rising edge, every channel SHALL go to IDLE with count=0, done=0, busy=0 and mode=0.
REQ-035 Reset SHALL set term_reg=DEFAULT_TERM and active_term=DEFAULT_TERM.
REQ-036 Reset SHALL override all other inputs, including a reset asserted mid-count, and SHALL produce no done pulse.
REQ-037 Reset SHALL take effect only on a clock edge (synchronous).

Verification (WIDTH=8, NUM_CH=4)
REQ-038 One-shot: load ch0=5, start ch0 -> done[0] high exactly 5 cycles after the start edge, busy[0] falls in the same cycle, and no further done.
REQ-039 Periodic: load ch1=3, start with periodic[1]=1 -> done[1] every 3 cycles for 4 periods; stop -> count 0, busy 0 and no done on the next edge.
REQ-040 Pause: ch2 term=6, pause for 4 cycles at count=2 -> count holds at 2, and done arrives 6+4 cycles after start.
REQ-041 Collisions: stop+start same cycle -> IDLE; start at count==term-1 -> restart with no done; load 0 -> term 1, so periodic gives done every cycle.
REQ-042 Reset mid-run at count=4 -> all outputs 0 next cycle, and term_reg reads back as DEFAULT_TERM mod 2^8 on the next start.
REQ-043 Independence: all 4 channels run with terms 2,3,4,5 concurrently -> each done pulse matches its own period, with no cross-talk.
